// File: rtl/dbus_sram_responder_pkg.sv
// Shared types for the data-bus SRAM responder.
// Holds the CPU data-bus request/response structs, the access-size codes,
// the responder FSM state enum and the alignment helper.
package dbus_sram_responder_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dresp_state_t;

    // Byte accesses never fault; halfwords need addr[0]==0, words addr[1:0]==0.
    function automatic logic misaligned(input msize_t size, input logic [1:0] lsb);
        return ((size == MSIZE2) && lsb[0]) || ((size == MSIZE4) && (lsb != 2'b00));
    endfunction

endpackage

// File: rtl/dbus_sram_responder_array.sv
// Word-organized storage behind the responder.
// Ports: clk; rd_idx -> rd_data (asynchronous read);
//        wr_en, wr_idx, wr_be[3:0], wr_data (synchronous byte-enabled write).
// Contents are not reset.
module dbus_sram_responder_array #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] rd_idx,
    output logic [31:0]          rd_data,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_idx,
    input  logic [3:0]           wr_be,
    input  logic [31:0]          wr_data
);

    logic [31:0] mem_q [0:(1<<ADDR_BITS)-1];

    assign rd_data = mem_q[rd_idx];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_be[i]) begin
                mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by on-chip SRAM, one outstanding request.
// Ports: clk, resetn (async, active low); req (dbus_req_t) from the CPU;
//        resp (dbus_resp_t: addr_ok combinational, data_ok/data registered);
//        err (misaligned flag, meaningful only with resp.data_ok).
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | no transaction
// WAIT  | transaction latched, cnt counting down
// RESP  | data_ok cycle; write commits at its closing edge
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  dbus_req_t  req,
    output dbus_resp_t resp,
    output logic       err
);

    localparam int AW = ADDR_BITS + 2;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dresp_state_t         state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [AW-1:0]        addr_q, addr_d;
    msize_t               size_q, size_d;
    logic [3:0]           strb_q, strb_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 data_ok_q, data_ok_d;
    logic                 err_q, err_d;

    logic                 addr_ok;
    logic [AW-1:0]        src_addr;
    msize_t               src_size;
    logic                 src_mis;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] rd_idx, wr_idx;
    logic [31:0]          arr_rdata, fwd_word;

    assign addr_ok = req.valid && ((state_q == IDLE) || (state_q == RESP)) && resetn;

    // The transaction whose data is captured at this edge: the one being
    // accepted (LATENCY==1) or the latched one leaving WAIT.
    assign src_addr = addr_ok ? req.addr[AW-1:0] : addr_q;
    assign src_size = addr_ok ? req.size : size_q;
    assign src_mis  = misaligned(src_size, src_addr[1:0]);

    assign rd_idx = src_addr[AW-1:2];
    assign wr_idx = addr_q[AW-1:2];
    assign wr_en  = (state_q == RESP) && !misaligned(size_q, addr_q[1:0]);

    dbus_sram_responder_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk     (clk),
        .rd_idx  (rd_idx),
        .rd_data (arr_rdata),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_be   (strb_q),
        .wr_data (wdata_q)
    );

    // Back-to-back at LATENCY==1 reads at the same edge the previous write
    // commits, so merge the pending write bytes into the read word.
    always_comb begin
        fwd_word = arr_rdata;
        for (int i = 0; i < 4; i++) begin
            if (wr_en && strb_q[i] && (wr_idx == rd_idx)) begin
                fwd_word[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;

        unique case (state_q)
            IDLE, RESP: begin
                if (addr_ok) begin
                    addr_d  = req.addr[AW-1:0];
                    size_d  = req.size;
                    strb_d  = req.strobe;
                    wdata_d = req.data;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        data_ok_d = (state_d == RESP);
        err_d     = data_ok_d && src_mis;
        rdata_d   = (data_ok_d && !src_mis) ? fwd_word : 32'd0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            size_q    <= MSIZE1;
            strb_q    <= 4'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            data_ok_q <= data_ok_d;
            err_q     <= err_d;
        end
    end

    assign resp.addr_ok = addr_ok;
    assign resp.data_ok = data_ok_q;
    assign resp.data    = rdata_q;
    assign err          = err_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 1) share clock and reset.
// Drivers push expected responses computed from a byte-level memory model;
// a negedge monitor pops and compares whenever data_ok is seen.
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [31:0] mask;
        logic        err;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    dbus_req_t  req0, req1;
    dbus_resp_t resp0, resp1;
    logic       err0, err1;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    bit  started = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    bit [31:0] mdl_w [int];
    bit [3:0]  mdl_k [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbus_sram_responder #(.ADDR_BITS(10), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .resetn(resetn), .req(req0), .resp(resp0), .err(err0));
    dbus_sram_responder #(.ADDR_BITS(10), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .resetn(resetn), .req(req1), .resp(resp1), .err(err1));

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int k);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    // Reference model: the access is resolved in full at acceptance time,
    // since every earlier write has committed before this read happens.
    task automatic model_accept(input int k, input logic [31:0] a, input msize_t sz,
                                input logic [3:0] st, input logic [31:0] d);
        int        idx, key;
        bit        mis;
        bit [31:0] w;
        bit [3:0]  km;
        exp_t      e;
        idx = int'((a / 4) % 1024);
        key = k * 1024 + idx;
        mis = ((sz == MSIZE2) && (a % 2 != 0)) || ((sz == MSIZE4) && (a % 4 != 0));
        w   = mdl_w.exists(key) ? mdl_w[key] : 32'd0;
        km  = mdl_k.exists(key) ? mdl_k[key] : 4'd0;
        e.cyc  = cyc + ((k == 0) ? LAT0 : LAT1);
        e.err  = mis;
        e.data = mis ? 32'd0 : w;
        e.mask = 32'd0;
        for (int i = 0; i < 4; i++) if (mis || km[i]) e.mask[8*i +: 8] = 8'hFF;
        if (!mis) begin
            for (int i = 0; i < 4; i++) begin
                if (st[i]) begin
                    w[8*i +: 8] = d[8*i +: 8];
                    km[i] = 1'b1;
                end
            end
            mdl_w[key] = w;
            mdl_k[key] = km;
        end
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int k, input logic [31:0] a, input msize_t sz,
                         input logic [3:0] st, input logic [31:0] d, output int waits);
        dbus_req_t r;
        bit ok;
        r.valid = 1'b1; r.addr = a; r.size = sz; r.strobe = st; r.data = d;
        if (k == 0) req0 = r; else req1 = r;
        waits = 0;
        ok = 1'b0;
        while (!ok && waits <= 40) begin
            @(negedge clk);
            if ((k == 0) ? resp0.addr_ok : resp1.addr_ok) ok = 1'b1;
            else waits++;
        end
        if (!ok) begin
            chk(1'b0, $sformatf("addr_ok_timeout[%0d]", k), 32'd0, 32'd1);
        end else begin
            model_accept(k, a, sz, st, d);
            @(posedge clk);
            #1;
        end
        if (k == 0) req0.valid = 1'b0; else req1.valid = 1'b0;
    endtask

    task automatic check_port(input int k);
        dbus_resp_t r;
        dbus_req_t  q;
        logic       e;
        exp_t       x;
        r = (k == 0) ? resp0 : resp1;
        q = (k == 0) ? req0 : req1;
        e = (k == 0) ? err0 : err1;
        if (!q.valid) chk(!r.addr_ok, $sformatf("addr_ok_without_valid[%0d]", k), {31'd0, r.addr_ok}, 32'd0);
        while (qsize(k) > 0 && qfront(k).cyc < cyc) begin
            chk(1'b0, $sformatf("missing_data_ok[%0d]", k), 32'd0, 32'(qfront(k).cyc));
            qpop(k);
        end
        if (r.data_ok) begin
            if (qsize(k) == 0) begin
                chk(1'b0, $sformatf("unexpected_data_ok[%0d]", k), r.data, 32'd0);
            end else begin
                x = qfront(k);
                qpop(k);
                chk(cyc == x.cyc, $sformatf("latency[%0d]", k), 32'(cyc), 32'(x.cyc));
                chk((r.data & x.mask) == (x.data & x.mask), $sformatf("rdata[%0d]", k),
                    r.data & x.mask, x.data & x.mask);
                chk(e == x.err, $sformatf("err[%0d]", k), {31'd0, e}, {31'd0, x.err});
            end
        end else begin
            chk((r.data == 32'd0) && (e == 1'b0), $sformatf("idle_outputs_zero[%0d]", k),
                r.data | {31'd0, e}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (started && resetn) begin
            check_port(0);
            check_port(1);
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk(q0.size() == 0 && q1.size() == 0, "drain", 32'(q0.size() + q1.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rand_run(input int k, input int n);
        logic [31:0] a;
        msize_t      sz;
        logic [3:0]  st;
        int          w, gap;
        for (int i = 0; i < n; i++) begin
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            sz = msize_t'($urandom_range(0, 2));
            st = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            issue(k, a, sz, st, $urandom, w);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int w;
        dbus_req_t r;
        bit ok;
        req0 = '0;
        req1 = '0;
        req0.valid = 1'b1;
        req1.valid = 1'b1;
        repeat (2) @(negedge clk);
        chk(resp0 == '0 && err0 == 1'b0, "reset_outputs[0]", resp0.data | {30'd0, resp0.addr_ok, resp0.data_ok}, 32'd0);
        chk(resp1 == '0 && err1 == 1'b0, "reset_outputs[1]", resp1.data | {30'd0, resp1.addr_ok, resp1.data_ok}, 32'd0);
        req0.valid = 1'b0;
        req1.valid = 1'b0;
        @(posedge clk);
        #1;
        resetn  = 1'b1;
        started = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases on the LATENCY=2 responder.
        issue(0, 32'h10, MSIZE4, 4'hF, 32'hDEAD_BEEF, w);
        chk(w == 0, "addr_ok_first_cycle", 32'(w), 32'd0);
        issue(0, 32'h10, MSIZE4, 4'h0, 32'h0, w);
        issue(0, 32'h10, MSIZE4, 4'hF, 32'h1122_3344, w);
        issue(0, 32'h13, MSIZE1, 4'b1000, 32'hAA00_0000, w);
        issue(0, 32'h10, MSIZE4, 4'h0, 32'h0, w);
        issue(0, 32'h12, MSIZE4, 4'hF, 32'h0BAD_0BAD, w);
        issue(0, 32'h10, MSIZE4, 4'h0, 32'h0, w);
        issue(0, 32'h0000_1004, MSIZE4, 4'hF, 32'h1234_5678, w);
        issue(0, 32'h0000_0004, MSIZE4, 4'h0, 32'h0, w);
        issue(0, 32'h22, MSIZE2, 4'h3, 32'h0000_9999, w);
        issue(0, 32'h21, MSIZE2, 4'h3, 32'h0000_7777, w);

        // LATENCY=1 streaming with valid held high.
        issue(1, 32'h0, MSIZE4, 4'hF, 32'hA0A0_0000, w);
        issue(1, 32'h4, MSIZE4, 4'hF, 32'hA0A0_0004, w);
        issue(1, 32'h8, MSIZE4, 4'hF, 32'hA0A0_0008, w);
        for (int i = 0; i < 3; i++) begin
            issue(1, 32'(4 * i), MSIZE4, 4'h0, 32'h0, w);
            chk(w == 0, "stream_addr_ok", 32'(w), 32'd0);
        end
        issue(1, 32'h8, MSIZE1, 4'b0010, 32'h0000_5A00, w);
        issue(1, 32'h8, MSIZE4, 4'h0, 32'h0, w);
        chk(w == 0, "raw_back_to_back_addr_ok", 32'(w), 32'd0);
        wait_drain();

        // Reset while the LATENCY=2 write sits in WAIT: no response, no write.
        r.valid = 1'b1; r.addr = 32'h20; r.size = MSIZE4; r.strobe = 4'hF; r.data = 32'hCAFE_F00D;
        req0 = r;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = resp0.addr_ok;
        end
        chk(ok, "reset_test_accept", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        req0.valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk(resp0.data_ok == 1'b0 && resp0.data == 32'd0, "async_reset_outputs", resp0.data, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(resp0.data_ok == 1'b0, "data_ok_in_reset", {31'd0, resp0.data_ok}, 32'd0);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(resp0.data_ok == 1'b0, "data_ok_after_abort", {31'd0, resp0.data_ok}, 32'd0);
        end
        @(posedge clk);
        #1;
        issue(0, 32'h20, MSIZE4, 4'hF, 32'h5555_5555, w);
        issue(0, 32'h20, MSIZE4, 4'h0, 32'h0, w);
        wait_drain();

        // Make the random region fully known, then randomize both ports at once.
        for (int i = 0; i < 16; i++) begin
            issue(0, 32'(4 * i), MSIZE4, 4'hF, $urandom, w);
            issue(1, 32'(4 * i), MSIZE4, 4'hF, $urandom, w);
        end
        fork
            rand_run(0, 150);
            rand_run(1, 150);
        join
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

endmodule
